spi_slave_port: RTL and testbench

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_slave_port_if.sv | 17 +
 rtl/spi_sync_2ff.sv | 19 +
 rtl/spi_slave_port.sv | 117 +++++++++++
 tb/tb_spi_slave_port.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI slave port.
package spi_pkg;
  localparam int DEF_REG_WIDTH = 32;
  localparam int SYNC_DEPTH    = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
endpackage

// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: SPI pins plus the parallel word side of spi_slave_port.
//   slave  modport: sclk/cs_n/mosi/d_in in; miso/miso_oe/d_out/done/busy out
//   master modport: mirror image, used by whatever drives the port
//   err is present only with SPI_SLAVE_PORT_ERR_EN defined.
interface spi_slave_port_if #(parameter int REG_WIDTH = spi_pkg::DEF_REG_WIDTH);
  logic                 sclk, cs_n, mosi, miso, miso_oe;
  logic [REG_WIDTH-1:0] d_in, d_out;
  logic                 done, busy;
`ifdef SPI_SLAVE_PORT_ERR_EN
  logic                 err;
  modport slave  (input sclk, cs_n, mosi, d_in, output miso, miso_oe, d_out, done, busy, err);
  modport master (output sclk, cs_n, mosi, d_in, input miso, miso_oe, d_out, done, busy, err);
`else
  modport slave  (input sclk, cs_n, mosi, d_in, output miso, miso_oe, d_out, done, busy);
  modport master (output sclk, cs_n, mosi, d_in, input miso, miso_oe, d_out, done, busy);
`endif
endinterface

// File: rtl/spi_sync_2ff.sv
// spi_sync_2ff: SYNC_DEPTH-flop synchronizer for one asynchronous input.
//   clk, rst (async active-low), d_i raw input, q_o synchronized output.
//   RST_VAL is the idle level the chain holds in reset.
module spi_sync_2ff
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_DEPTH-1:0] sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= {SYNC_DEPTH{RST_VAL}};
    else      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
  assign q_o = sync_q[SYNC_DEPTH-1];
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave, MSB first, full duplex, REG_WIDTH-bit words.
//   clk  system clock, rst async active-low reset
//   bus  spi_slave_port_if.slave: sclk/cs_n/mosi from master, miso/miso_oe back,
//        d_in word to send (sampled at selection), d_out last received word,
//        done one-clk pulse on d_out update, busy while a word is in flight.
//   Optional macro SPI_SLAVE_PORT_ERR_EN adds err: one-clk pulse on an abort
//   (deselect mid-word) or on an sclk rising edge after the word completed.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input logic clk,
  input logic rst,
  spi_slave_port_if.slave bus
);
  localparam int CW = $clog2(REG_WIDTH + 1);
  logic                 sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic                 sclk_rise, sclk_fall, cs_fall, last_bit;
  state_t               state_q;
  logic [REG_WIDTH-1:0] tx_q, dout_q, rx_d;
  // The final bit goes straight into d_out, so only REG_WIDTH-1 bits are stored.
  logic [REG_WIDTH-2:0] rx_q;
  logic [CW-1:0]        cnt_q;
  logic                 miso_q, oe_q, busy_q, done_q;
`ifdef SPI_SLAVE_PORT_ERR_EN
  logic                 err_q;
`endif
  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(bus.sclk), .q_o(sclk_s));
  spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(bus.cs_n), .q_o(cs_s));
  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(bus.mosi), .q_o(mosi_s));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign rx_d      = {rx_q, mosi_s};
  assign last_bit  = cnt_q == CW'(REG_WIDTH - 1);
  // IDLE only reacts to selection, so an sclk edge coinciding with cs_n falling is dropped.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_SLAVE_PORT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SPI_SLAVE_PORT_ERR_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE:
          if (cs_fall) begin
            tx_q    <= bus.d_in;
            cnt_q   <= '0;
            miso_q  <= bus.d_in[REG_WIDTH-1];
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        SHIFT:
          if (cs_s) begin
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef SPI_SLAVE_PORT_ERR_EN
            err_q   <= 1'b1;
`endif
          end else if (sclk_rise) begin
            rx_q  <= rx_d[REG_WIDTH-2:0];
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
              dout_q  <= rx_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              miso_q  <= 1'b0;
              state_q <= HOLD;
            end
          end else if (sclk_fall) begin
            tx_q   <= tx_q << 1;
            miso_q <= tx_q[REG_WIDTH-2];
          end
        HOLD:
          if (cs_s) begin
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
`ifdef SPI_SLAVE_PORT_ERR_EN
          else if (sclk_rise) err_q <= 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  assign bus.miso    = miso_q;
  assign bus.miso_oe = oe_q;
  assign bus.d_out   = dout_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
`ifdef SPI_SLAVE_PORT_ERR_EN
  assign bus.err     = err_q;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: self-checking bench for spi_slave_port (table vectors, hand sequences, random words).
module tb_spi_slave_port;
  localparam int W = 32;
  typedef struct {
    string        nm;
    logic [W-1:0] din, mo;
    int           nbits;
    bit           coinc;
    logic [W-1:0] exp_dout, exp_miso;
    int           exp_done;
  } vec_t;
  logic         clk = 1'b0, rst = 1'b0;
  int           n_vec = 0, n_bad = 0, done_cnt = 0;
  logic         done_prev = 1'b0;
  logic [W-1:0] done_dout = '0, exp_dout = '0;
`ifdef SPI_SLAVE_PORT_ERR_EN
  int           err_cnt = 0;
`endif
  vec_t         tbl[6];
  spi_slave_port_if #(.REG_WIDTH(W)) bus ();
  spi_slave_port #(.REG_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_dout = bus.d_out;
      chk("done_one_clk", {31'b0, done_prev}, '0);
    end
    done_prev = bus.done;
`ifdef SPI_SLAVE_PORT_ERR_EN
    if (bus.err) err_cnt++;
`endif
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // coinc makes an sclk falling edge land in the same cycle as cs_n falling.
  task automatic select(input logic [W-1:0] din, input bit coinc);
    bus.d_in = din;
    if (coinc) begin
      bus.sclk = 1'b1;
      tick(4);
    end
    bus.cs_n = 1'b0;
    bus.sclk = 1'b0;
    tick(4);
    bus.d_in = ~din;
  endtask
  // One clk/8 sclk period: mosi set on the low phase, miso sampled just before the rise.
  task automatic send_bit(input logic b, output logic m);
    bus.mosi = b;
    tick(4);
    m = bus.miso;
    bus.sclk = 1'b1;
    tick(4);
    bus.sclk = 1'b0;
  endtask
  task automatic run(input string nm, input logic [W-1:0] din, input logic [W-1:0] mo, input int nbits,
                     input bit coinc, input logic [W-1:0] e_dout, input logic [W-1:0] e_miso, input int e_done);
    int           d0;
    int           extra;
    logic         m;
    logic [W-1:0] mi;
`ifdef SPI_SLAVE_PORT_ERR_EN
    int           e0 = err_cnt;
`endif
    d0 = done_cnt;
    mi = '0;
    extra = 0;
    select(din, coinc);
    for (int i = 0; i < nbits; i++) begin
      send_bit(i < W ? mo[W-1-i] : 1'b1, m);
      if (i < W) mi[W-1-i] = m;
      else extra += int'(m);
    end
    tick(4);
    chk({nm, ".busy"}, {31'b0, bus.busy}, {31'b0, nbits < W});
    chk({nm, ".oe_sel"}, {31'b0, bus.miso_oe}, 1);
    bus.cs_n = 1'b1;
    tick(8);
    chk({nm, ".dout"}, bus.d_out, e_dout);
    chk({nm, ".done"}, done_cnt - d0, e_done);
    chk({nm, ".miso_word"}, mi, e_miso);
    chk({nm, ".miso_hold"}, extra, 0);
    chk({nm, ".desel"}, {29'b0, bus.miso, bus.miso_oe, bus.busy}, '0);
    if (e_done > 0) chk({nm, ".dout_at_done"}, done_dout, e_dout);
`ifdef SPI_SLAVE_PORT_ERR_EN
    chk({nm, ".err"}, err_cnt - e0, nbits < W ? 1 : nbits - W);
`endif
  endtask
  initial begin
    int           d0;
    int           nb;
    logic         m;
    logic [W-1:0] din, mo, ones;
    ones = '1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.d_in = '0;
    tick(2);
    chk("reset.dout", bus.d_out, '0);
    chk("reset.flags", {28'b0, bus.done, bus.busy, bus.miso, bus.miso_oe}, '0);
    rst = 1'b1;
    tick(4);
    tbl[0] = '{"full",     32'ha800_0787, 32'ha800_0545, 32, 1'b0, 32'ha800_0545, 32'ha800_0787, 1};
    tbl[1] = '{"b2b",      32'ha800_0191, 32'ha800_0454, 32, 1'b0, 32'ha800_0454, 32'ha800_0191, 1};
    tbl[2] = '{"abort12",  32'h1234_5678, 32'hffff_ffff, 12, 1'b0, 32'ha800_0454, 32'h1230_0000, 0};
    tbl[3] = '{"extra34",  32'h0f0f_0f0f, 32'h5a5a_c3c3, 34, 1'b0, 32'h5a5a_c3c3, 32'h0f0f_0f0f, 1};
    tbl[4] = '{"coincide", 32'hc3c3_a5a5, 32'h0000_ffff, 32, 1'b1, 32'h0000_ffff, 32'hc3c3_a5a5, 1};
    tbl[5] = '{"abort0",   32'h8000_0001, 32'h0000_0001, 0,  1'b0, 32'h0000_ffff, 32'h0000_0000, 0};
    for (int v = 0; v < 6; v++)
      run(tbl[v].nm, tbl[v].din, tbl[v].mo, tbl[v].nbits, tbl[v].coinc, tbl[v].exp_dout, tbl[v].exp_miso, tbl[v].exp_done);
    exp_dout = 32'h0000_ffff;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.sclk = ~bus.sclk;
      tick(2);
      chk("desel.idle", {29'b0, bus.miso, bus.miso_oe, bus.busy}, '0);
    end
    bus.sclk = 1'b0;
    tick(4);
    chk("desel.done", done_cnt - d0, 0);
    d0 = done_cnt;
    select(32'haaaa_5555, 1'b0);
    mo = 32'hffff_0000;
    for (int i = 0; i < 20; i++) send_bit(mo[W-1-i], m);
    rst = 1'b0;
    #1;
    chk("rst_mid.dout", bus.d_out, '0);
    chk("rst_mid.flags", {28'b0, bus.done, bus.busy, bus.miso, bus.miso_oe}, '0);
    tick(2);
    bus.cs_n = 1'b1;
    rst = 1'b1;
    tick(8);
    chk("rst_mid.done", done_cnt - d0, 0);
    exp_dout = '0;
    run("post_rst", 32'h1357_9bdf, 32'h2468_ace0, 32, 1'b0, 32'h2468_ace0, 32'h1357_9bdf, 1);
    exp_dout = 32'h2468_ace0;
    for (int r = 0; r < 8; r++) begin
      din = $urandom;
      mo  = $urandom;
      case ($urandom_range(0, 3))
        0:       nb = $urandom_range(1, 31);
        1:       nb = $urandom_range(33, 35);
        default: nb = 32;
      endcase
      if (nb >= W) exp_dout = mo;
      run("rand", din, mo, nb, 1'b0, exp_dout, nb >= W ? din : din & ~(ones >> nb), nb >= W ? 1 : 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
